// File: rtl/reg_file_sb_if.sv
// Register-file bus: operand/branch read ports, ALU and ID write ports,
// scoreboard claim port and scoreboard status.
interface reg_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
);
    logic [ADDR_W-1:0]   read_addr1;
    logic [ADDR_W-1:0]   read_addr2;
    logic [ADDR_W-1:0]   br_addr;
    logic [DATA_W-1:0]   reg1_val;
    logic [DATA_W-1:0]   reg2_val;
    logic [DATA_W-1:0]   br_value;
    logic                reg1_busy;
    logic                reg2_busy;
    logic                br_busy;

    logic                alu_we;
    logic [ADDR_W-1:0]   alu_waddr;
    logic [DATA_W-1:0]   alu_wdata;
    logic                id_we;
    logic [ADDR_W-1:0]   id_waddr;
    logic [DATA_W-1:0]   id_wdata;

    logic                claim_en;
    logic [ADDR_W-1:0]   claim_addr;
    logic [NUM_REGS-1:0] busy_vec;
    logic                wr_conflict;

    modport master (
        output read_addr1, read_addr2, br_addr,
        output alu_we, alu_waddr, alu_wdata, id_we, id_waddr, id_wdata,
        output claim_en, claim_addr,
        input  reg1_val, reg2_val, br_value, reg1_busy, reg2_busy, br_busy,
        input  busy_vec, wr_conflict
    );

    modport slave (
        input  read_addr1, read_addr2, br_addr,
        input  alu_we, alu_waddr, alu_wdata, id_we, id_waddr, id_wdata,
        input  claim_en, claim_addr,
        output reg1_val, reg2_val, br_value, reg1_busy, reg2_busy, br_busy,
        output busy_vec, wr_conflict
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two prioritised write ports, optional write-to-read
// bypass, optional hardwired-zero R0 and a per-register busy scoreboard.

// One register plus its scoreboard bit.
module reg_file_sb_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              claim,
    output logic [DATA_W-1:0] q,
    output logic              busy
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (we)
                q <= wdata;
            // A same-cycle claim wins: the newer producer is still outstanding.
            if (claim)
                busy <= 1'b1;
            else if (we)
                busy <= 1'b0;
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int R0_ZERO  = 0
) (
    input logic         clk,
    input logic         reset,
    reg_file_sb_if.slave bus
);
    localparam int  NUM_RD = 3;
    localparam bit  BYP    = (BYPASS != 0);
    localparam bit  R0Z    = (R0_ZERO != 0);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic [NUM_REGS-1:0]             busy;
    logic                            conflict_d;

    // Per-register write steering: ALU data wins when both ports hit.
    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            localparam bit ZERO_REG = R0Z && (i == 0);
            logic              alu_hit;
            logic              id_hit;
            logic              claim_hit;
            logic              we;
            logic [DATA_W-1:0] wdata;

            assign alu_hit   = !ZERO_REG && bus.alu_we   && (bus.alu_waddr  == ADDR_W'(i));
            assign id_hit    = !ZERO_REG && bus.id_we    && (bus.id_waddr   == ADDR_W'(i));
            assign claim_hit = !ZERO_REG && bus.claim_en && (bus.claim_addr == ADDR_W'(i));
            assign we        = alu_hit || id_hit;
            assign wdata     = alu_hit ? bus.alu_wdata : bus.id_wdata;

            reg_file_sb_cell #(.DATA_W(DATA_W)) u_cell (
                .clk   (clk),
                .reset (reset),
                .we    (we),
                .wdata (wdata),
                .claim (claim_hit),
                .q     (mem[i]),
                .busy  (busy[i])
            );
        end
    endgenerate

    // Read ports: 0 = operand 1, 1 = operand 2, 2 = branch target.
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_val;
    logic [NUM_RD-1:0]             rd_busy;

    assign rd_addr = {bus.br_addr, bus.read_addr2, bus.read_addr1};

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            logic              alu_m;
            logic              id_m;
            logic              zero_m;
            logic [DATA_W-1:0] val;
            logic              bsy;

            assign alu_m  = BYP && bus.alu_we && (bus.alu_waddr == rd_addr[p]);
            assign id_m   = BYP && bus.id_we  && (bus.id_waddr  == rd_addr[p]);
            assign zero_m = R0Z && (rd_addr[p] == '0);

            always_comb begin
                val = mem[rd_addr[p]];
                bsy = busy[rd_addr[p]];
                if (alu_m)
                    val = bus.alu_wdata;
                else if (id_m)
                    val = bus.id_wdata;
                // A write landing this cycle retires the pending value.
                if (alu_m || id_m)
                    bsy = 1'b0;
                if (zero_m) begin
                    val = '0;
                    bsy = 1'b0;
                end
            end

            assign rd_val[p]  = val;
            assign rd_busy[p] = bsy;
        end
    endgenerate

    assign bus.reg1_val  = rd_val[0];
    assign bus.reg2_val  = rd_val[1];
    assign bus.br_value  = rd_val[2];
    assign bus.reg1_busy = rd_busy[0];
    assign bus.reg2_busy = rd_busy[1];
    assign bus.br_busy   = rd_busy[2];
    assign bus.busy_vec  = busy;

    // Writes to a hardwired-zero R0 are discarded, so they cannot collide.
    assign conflict_d = bus.alu_we && bus.id_we && (bus.alu_waddr == bus.id_waddr) &&
                        !(R0Z && (bus.alu_waddr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.wr_conflict <= 1'b0;
        else
            bus.wr_conflict <= conflict_d;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with bypass, one with
// registered-only reads and hardwired-zero R0, checked through a FIFO scoreboard.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3)) ia ();
    reg_file_sb_if #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3)) ib ();

    reg_file_sb #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1), .R0_ZERO(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ia));
    reg_file_sb #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .BYPASS(0), .R0_ZERO(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ib));

    logic [31:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic idle();
        ia.alu_we = 1'b0; ia.id_we = 1'b0; ia.claim_en = 1'b0;
        ib.alu_we = 1'b0; ib.id_we = 1'b0; ib.claim_en = 1'b0;
    endtask

    initial begin
        ia.read_addr1 = '0; ia.read_addr2 = '0; ia.br_addr = '0;
        ia.alu_waddr = '0; ia.alu_wdata = '0; ia.id_waddr = '0; ia.id_wdata = '0;
        ia.claim_addr = '0;
        ib.read_addr1 = '0; ib.read_addr2 = '0; ib.br_addr = '0;
        ib.alu_waddr = '0; ib.alu_wdata = '0; ib.id_waddr = '0; ib.id_wdata = '0;
        ib.claim_addr = '0;
        idle();
        reset = 1'b1;
        #3;
        push(0); chk("rst_reg1", ia.reg1_val);
        push(0); chk("rst_busy_vec", 32'(ia.busy_vec));
        push(0); chk("rst_conflict", 32'(ia.wr_conflict));
        @(negedge clk) reset = 1'b0;

        // Preload r3 and claim it, then reset asynchronously between edges.
        @(negedge clk);
        ia.alu_we = 1'b1; ia.alu_waddr = 3; ia.alu_wdata = 32'h1234;
        ia.claim_en = 1'b1; ia.claim_addr = 3; ia.read_addr1 = 3;
        @(posedge clk) #1 idle();
        #1;
        push(32'h1234); chk("preload_r3", ia.reg1_val);
        push(32'h08);   chk("preload_busy", 32'(ia.busy_vec));
        #2 reset = 1'b1;
        #1;
        push(0); chk("async_rst_reg1", ia.reg1_val);
        push(0); chk("async_rst_busy", 32'(ia.busy_vec));
        // Write held across an edge while reset is asserted must be dropped.
        ia.alu_we = 1'b1; ia.alu_waddr = 7; ia.alu_wdata = 32'h77;
        @(posedge clk) #1;
        @(negedge clk) idle();
        reset = 1'b0; ia.read_addr2 = 7;
        #1;
        push(0); chk("rst_drops_write", ia.reg2_val);

        // Dual write to different addresses.
        @(negedge clk);
        ia.alu_we = 1'b1; ia.alu_waddr = 2; ia.alu_wdata = 32'hAAAA0000;
        ia.id_we  = 1'b1; ia.id_waddr  = 5; ia.id_wdata  = 32'h5555;
        @(posedge clk) #1 idle();
        ia.read_addr1 = 2; ia.read_addr2 = 5;
        #1;
        push(32'hAAAA0000); chk("dual_r2", ia.reg1_val);
        push(32'h5555);     chk("dual_r5", ia.reg2_val);
        push(0);            chk("dual_no_conflict", 32'(ia.wr_conflict));

        // Same-address conflict: ALU wins, one-cycle wr_conflict pulse.
        @(negedge clk);
        ia.alu_we = 1'b1; ia.alu_waddr = 4; ia.alu_wdata = 32'h11;
        ia.id_we  = 1'b1; ia.id_waddr  = 4; ia.id_wdata  = 32'h22;
        ia.read_addr1 = 4;
        #1;
        push(32'h11); chk("conflict_bypass_prio", ia.reg1_val);
        @(posedge clk) #1 idle();
        #1;
        push(32'h11); chk("conflict_r4", ia.reg1_val);
        push(1);      chk("conflict_pulse", 32'(ia.wr_conflict));
        @(posedge clk) #1;
        push(0);      chk("conflict_pulse_end", 32'(ia.wr_conflict));

        // Bypass vs registered-only read of r6.
        @(negedge clk);
        ia.alu_we = 1'b1; ia.alu_waddr = 6; ia.alu_wdata = 32'hDEAD; ia.read_addr1 = 6;
        ib.alu_we = 1'b1; ib.alu_waddr = 6; ib.alu_wdata = 32'hDEAD; ib.read_addr1 = 6;
        #1;
        push(32'hDEAD); chk("bypass_on_pre", ia.reg1_val);
        push(0);        chk("bypass_off_pre", ib.reg1_val);
        @(posedge clk) #1 idle();
        #1;
        push(32'hDEAD); chk("bypass_on_post", ia.reg1_val);
        push(32'hDEAD); chk("bypass_off_post", ib.reg1_val);

        // Scoreboard: claim, clear by ID write, claim+write, re-claim.
        @(negedge clk);
        ia.claim_en = 1'b1; ia.claim_addr = 1; ia.read_addr1 = 1; ia.br_addr = 1;
        @(posedge clk) #1 idle();
        #1;
        push(32'h02); chk("claim_busy_vec", 32'(ia.busy_vec));
        push(1);      chk("claim_reg1_busy", 32'(ia.reg1_busy));
        push(1);      chk("claim_br_busy", 32'(ia.br_busy));
        @(negedge clk);
        ia.id_we = 1'b1; ia.id_waddr = 1; ia.id_wdata = 32'h77;
        #1;
        push(32'h77); chk("id_bypass_val", ia.reg1_val);
        push(0);      chk("id_bypass_busy", 32'(ia.reg1_busy));
        @(posedge clk) #1 idle();
        #1;
        push(0);      chk("id_clears_busy", 32'(ia.busy_vec));
        push(32'h77); chk("id_write_r1", ia.reg1_val);
        @(negedge clk);
        ia.claim_en = 1'b1; ia.claim_addr = 1;
        ia.alu_we = 1'b1; ia.alu_waddr = 1; ia.alu_wdata = 32'h99;
        @(posedge clk) #1 idle();
        #1;
        push(32'h99); chk("claim_write_val", ia.reg1_val);
        push(32'h02); chk("claim_write_busy", 32'(ia.busy_vec));
        @(negedge clk);
        ia.claim_en = 1'b1; ia.claim_addr = 1;
        ia.alu_we = 1'b1; ia.alu_waddr = 2; ia.alu_wdata = 32'h42;
        @(posedge clk) #1 idle();
        #1;
        push(32'h02); chk("reclaim_nonbusy_write", 32'(ia.busy_vec));

        // Hardwired-zero R0 on dut_b.
        @(negedge clk);
        ib.alu_we = 1'b1; ib.alu_waddr = 0; ib.alu_wdata = 32'hFFFF;
        ib.id_we  = 1'b1; ib.id_waddr  = 0; ib.id_wdata  = 32'h1234;
        ib.claim_en = 1'b1; ib.claim_addr = 0;
        ib.read_addr1 = 0; ib.br_addr = 0;
        @(posedge clk) #1 idle();
        #1;
        push(0); chk("r0_reg1", ib.reg1_val);
        push(0); chk("r0_br", ib.br_value);
        push(0); chk("r0_busy_vec", 32'(ib.busy_vec));
        push(0); chk("r0_no_conflict", 32'(ib.wr_conflict));

        // dut_b conflict on a real register still pulses.
        @(negedge clk);
        ib.alu_we = 1'b1; ib.alu_waddr = 4; ib.alu_wdata = 32'h11;
        ib.id_we  = 1'b1; ib.id_waddr  = 4; ib.id_wdata  = 32'h22;
        ib.read_addr2 = 4;
        @(posedge clk) #1 idle();
        #1;
        push(1);      chk("b_conflict_pulse", 32'(ib.wr_conflict));
        push(32'h11); chk("b_conflict_r4", ib.reg2_val);

        // Without bypass, busy stays visible until the write commits.
        @(negedge clk);
        ib.claim_en = 1'b1; ib.claim_addr = 3; ib.read_addr1 = 3;
        @(posedge clk) #1 idle();
        #1;
        push(32'h08); chk("b_claim_busy", 32'(ib.busy_vec));
        @(negedge clk);
        ib.alu_we = 1'b1; ib.alu_waddr = 3; ib.alu_wdata = 32'h5;
        #1;
        push(1); chk("b_busy_pre_edge", 32'(ib.reg1_busy));
        push(0); chk("b_val_pre_edge", ib.reg1_val);
        @(posedge clk) #1 idle();
        #1;
        push(0);     chk("b_busy_cleared", 32'(ib.busy_vec));
        push(32'h5); chk("b_val_post_edge", ib.reg1_val);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the SCC core. Successor to the fixed 8x32 single-write register file.
- Provides two operand read ports and one branch-target read port.
- Adds two independent write ports (ALU and ID) with fixed priority, optional same-cycle write-to-read bypass, and an optional hardwired-zero R0.
- Adds a per-register busy scoreboard so decode can detect pending writebacks and stall.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 8, number of registers; power of two, >= 2
ADDR_W, 3, address width; must equal log2(NUM_REGS)
BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value only
R0_ZERO, 0, 1 = register 0 reads as 0, ignores writes and claims

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
read_addr1  in  ADDR_W  operand port 1 address
read_addr2  in  ADDR_W  operand port 2 address
br_addr  in  ADDR_W  branch-target read address
reg1_val  out  DATA_W  value at read_addr1
reg2_val  out  DATA_W  value at read_addr2
br_value  out  DATA_W  value at br_addr
reg1_busy  out  1  scoreboard bit for read_addr1
reg2_busy  out  1  scoreboard bit for read_addr2
br_busy  out  1  scoreboard bit for br_addr
alu_we  in  1  ALU write enable (port A, high priority)
alu_waddr  in  ADDR_W  ALU write address
alu_wdata  in  DATA_W  ALU write data
id_we  in  1  ID write enable (port B, low priority)
id_waddr  in  ADDR_W  ID write address
id_wdata  in  DATA_W  ID write data
claim_en  in  1  mark a register as pending writeback
claim_addr  in  ADDR_W  register being claimed
busy_vec  out  NUM_REGS  all scoreboard bits; bit i = register i
wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address last cycle

Behaviour:
- Reset (asynchronous, reset=1): all registers = 0, busy_vec = 0, wr_conflict = 0. All read outputs therefore = 0 and all busy outputs = 0 while reset is held.
- Reset mid-operation discards pending writes and claims in that cycle.
- Read ports are combinational from the stored array plus the bypass path.
- Writes commit on the rising edge of clk.
- Port A (ALU) and port B (ID) may write different addresses in the same cycle; both commit.
- Same address, both enabled: ALU data commits, ID data is dropped. wr_conflict = 1 for exactly the following cycle, otherwise 0.
- Bypass, BYPASS=1: if a read address matches an enabled write address this cycle, the read returns that write data.
  - ALU data takes priority over ID data.
  - The matching busy output reads 0 (the write retires the pending value).
- Bypass, BYPASS=0: reads return the stored value; new data is visible the cycle after the edge.
- Scoreboard update at each edge, per register i:
  - set if claim_en and claim_addr == i;
  - else cleared if any enabled write targets i;
  - else held.
  - Claim and write to the same register in the same cycle: data is written and busy ends at 1 (the newer producer is outstanding).
- Claiming an already-busy register leaves it busy (no counting).
- R0_ZERO=1: register 0 always reads 0 on all ports, including via bypass. Writes to 0 are ignored and do not raise wr_conflict. Claims of 0 are ignored. busy_vec[0] is always 0.
- Writes to a non-busy register are legal and do not affect the scoreboard.
- Latency: read 0 cycles; write-to-read 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0); claim-to-busy 1 cycle.

Test Plan:
- Reset: preload r3=0x1234 then assert reset asynchronously between edges -> reg outputs=0 and busy_vec=0 immediately, with no clock edge needed.
- Dual write: alu_we writes r2=0xAAAA0000 and id_we writes r5=0x5555 in one cycle -> next cycle read r2=0xAAAA0000, r5=0x5555, wr_conflict=0.
- Conflict: both ports write r4 (ALU 0x11, ID 0x22) -> r4=0x11 afterwards; wr_conflict=1 for one cycle, then 0.
- Bypass: BYPASS=1 with read_addr1=6 and alu write r6=0xDEAD in the same cycle -> reg1_val=0xDEAD before the edge. BYPASS=0 -> old value before the edge, 0xDEAD after.
- Scoreboard: claim r1 -> busy_vec=0x02 next cycle and reg1_busy=1. ID write r1 -> busy cleared next cycle. Claim and write r1 in the same cycle -> data written, busy_vec[1]=1.
- R0_ZERO=1: ALU write r0=0xFFFF and claim r0 -> reg1_val at address 0 stays 0, busy_vec[0]=0, wr_conflict stays 0 even if ID also targets r0.
